// File: rtl/sequence_pattern_generator.sv
// Serialises a captured 4-bit pattern for (repeat_cnt+1) frames, with optional
// idle gaps between frames. Every output comes straight from a register.
module sequence_pattern_generator #(
    parameter logic IDLE_LEVEL = 1'b0,
    parameter int   MSB_FIRST  = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] pattern,
    input  logic [3:0] repeat_cnt,
    input  logic [2:0] gap,
    output logic       ready,
    output logic       O,
    output logic       valid,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t     state_q;
    logic [3:0] pattern_q;
    logic [3:0] frames_q;
    logic [2:0] gap_q;
    logic [2:0] gap_cnt_q;
    logic [1:0] bit_idx_q;
    logic       o_q;
    logic       valid_q;
    logic       ready_q;
    logic       done_q;

    assign ready = ready_q;
    assign O     = o_q;
    assign valid = valid_q;
    assign done  = done_q;

    // Bit idx of a frame maps to a pattern position according to the send order.
    function automatic logic pick_bit(input logic [3:0] pat, input logic [1:0] idx);
        if (MSB_FIRST != 0) begin
            pick_bit = pat[2'd3 - idx];
        end else begin
            pick_bit = pat[idx];
        end
    endfunction

    // Control FSM; O is loaded one cycle ahead so each bit index is already on the wire.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pattern_q <= 4'd0;
            frames_q  <= 4'd0;
            gap_q     <= 3'd0;
            gap_cnt_q <= 3'd0;
            bit_idx_q <= 2'd0;
            o_q       <= IDLE_LEVEL;
            valid_q   <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        pattern_q <= pattern;
                        frames_q  <= repeat_cnt;
                        gap_q     <= gap;
                        bit_idx_q <= 2'd0;
                        o_q       <= pick_bit(pattern, 2'd0);
                        valid_q   <= 1'b1;
                        ready_q   <= 1'b0;
                        state_q   <= ST_SEND;
                    end else begin
                        o_q     <= IDLE_LEVEL;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (bit_idx_q != 2'd3) begin
                        bit_idx_q <= bit_idx_q + 2'd1;
                        o_q       <= pick_bit(pattern_q, bit_idx_q + 2'd1);
                    end else if (frames_q != 4'd0) begin
                        frames_q  <= frames_q - 4'd1;
                        bit_idx_q <= 2'd0;
                        if (gap_q != 3'd0) begin
                            // Counter holds the gap cycles still to come after this one.
                            gap_cnt_q <= gap_q - 3'd1;
                            o_q       <= IDLE_LEVEL;
                            valid_q   <= 1'b0;
                            state_q   <= ST_GAP;
                        end else begin
                            o_q <= pick_bit(pattern_q, 2'd0);
                        end
                    end else begin
                        o_q     <= IDLE_LEVEL;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q != 3'd0) begin
                        gap_cnt_q <= gap_cnt_q - 3'd1;
                    end else begin
                        bit_idx_q <= 2'd0;
                        o_q       <= pick_bit(pattern_q, 2'd0);
                        valid_q   <= 1'b1;
                        state_q   <= ST_SEND;
                    end
                end
                default: begin
                    o_q     <= IDLE_LEVEL;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sequence_pattern_generator.md
SEQUENCE_PATTERN_GENERATOR -- requirements
Module: sequence_pattern_generator

Interface
REQ-001 SHALL have parameter IDLE_LEVEL, default 1'b0: the level driven on O whenever no pattern bit is being sent.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = send pattern[3] first; 0 = send pattern[0] first.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to send; accepted only on a rising edge where ready=1.
REQ-006 pattern  input  4  bit pattern to serialize; captured on acceptance.
REQ-007 repeat_cnt  input  4  number of frames minus 1 (1..16 frames); captured on acceptance.
REQ-008 gap  input  3  idle cycles inserted between frames (0..7); captured on acceptance.
REQ-009 ready  output  1  high when idle and able to accept start.
REQ-010 O  output  1  serial data out; drives the sequence detector input.
REQ-011 valid  output  1  high exactly in cycles where O carries a pattern bit.
REQ-012 done  output  1  one-cycle pulse after the last bit of the last frame.

Function
REQ-013 SHALL implement a 3-state FSM: IDLE, SEND, GAP.
REQ-014 SHALL drive all outputs (O, valid, ready, done) from registers, with no combinational path from inputs to outputs.
REQ-015 IDLE: ready=1, valid=0, O=IDLE_LEVEL; on edge N with start=1, SHALL capture pattern/repeat_cnt/gap, enter SEND with bit index 0, and set ready=0.
REQ-016 Latency: the first pattern bit SHALL appear on O, with valid=1, in the cycle following accepting edge N; bits occupy cycles N+1..N+4.
REQ-017 SEND: each cycle SHALL emit one bit in the order set by MSB_FIRST; the 2-bit bit index SHALL wrap 3->0 at frame end.
REQ-018 At the end of a frame, if frames remain and captured gap>0, SHALL enter GAP.
REQ-019 At the end of a frame, if frames remain and captured gap=0, SHALL stay in SEND and start the next frame with no idle cycle.
REQ-020 At the end of a frame, if no frames remain, SHALL enter IDLE.
REQ-021 GAP: SHALL hold O=IDLE_LEVEL, valid=0, ready=0 for exactly captured gap cycles, then return to SEND at bit index 0.
REQ-022 Frame counter: SHALL load repeat_cnt on acceptance and decrement at each frame end; the last frame is the one that ends with the counter at 0; no underflow.
REQ-023 done SHALL be high for exactly the first IDLE cycle after the last frame, coincident with ready returning to 1; it SHALL be low otherwise.
REQ-024 start while ready=0 SHALL be ignored; changes to pattern/repeat_cnt/gap while busy SHALL have no effect.
REQ-025 start accepted in the cycle where done=1 SHALL be honoured: done falls and the new first bit appears in the next cycle (back-to-back transactions, one idle cycle).
REQ-026 Total busy cycles per transaction SHALL be (repeat_cnt+1)*4 + repeat_cnt*gap.

Reset
REQ-027 reset=1 at a rising edge SHALL force IDLE: ready=1, valid=0, done=0, O=IDLE_LEVEL, and clear all counters and the captured pattern to 0.
REQ-028 reset SHALL take priority over start and SHALL abort a transfer mid-frame or mid-gap with no done pulse.
REQ-029 After reset deasserts, the first start SHALL be accepted on the next edge.

Verification
REQ-030 pattern=4'b1001, repeat_cnt=0, gap=0, MSB_FIRST=1 -> O=1,0,0,1 with valid=1 in cycles N+1..N+4; done=1 and ready=1 in N+5; a sequence detector fed from O asserts F once.
REQ-031 pattern=1001, repeat_cnt=2, gap=0 -> 12 contiguous valid bits 100110011001; done in cycle N+13.
REQ-032 pattern=1001, repeat_cnt=1, gap=2 -> O=1,0,0,1,0,0,1,0,0,1 with valid=0 only in cycles N+5 and N+6; done in N+11.
REQ-033 MSB_FIRST=0, pattern=4'b1000 -> O=0,0,0,1; start pulses during busy cycles -> ignored, no extra bits.
REQ-034 reset asserted in cycle N+2 of a 4-frame transfer -> next cycle ready=1, valid=0, O=IDLE_LEVEL, done stays 0; a new start then produces a correct frame.
REQ-035 start held high continuously with repeat_cnt=0 -> frames separated by exactly one done/ready cycle.
